// File: rtl/uart_tx_arbiter_ctrl.sv
// Round-robin shared UART transmitter: start, LSB-first data, optional parity and stop bits.
// Latency: Req in cycle n gives Ack and Tx=0 in cycle n+1. Backpressure: Req is held until Ack; requests are ignored while Busy.
module uart_tx_arbiter_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req0,
  input  logic [DATA_BITS-1:0] Data0,
  output logic                 Ack0,
  input  logic                 Req1,
  input  logic [DATA_BITS-1:0] Data1,
  output logic                 Ack1,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Grant_Id,
  output logic                 Flag_Tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud_cnt;
  logic [2:0]            r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic                  r_rr_ptr;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_grant_id;
  logic                  r_flag_tx;

  logic                  w_any_req;
  logic                  w_winner;
  logic [DATA_BITS-1:0]  w_win_data;
  logic                  w_bit_end;

  // On contention the pointer decides; a lone requester always wins.
  assign w_any_req  = Req0 | Req1;
  assign w_winner   = (Req0 & Req1) ? r_rr_ptr : Req1;
  assign w_win_data = w_winner ? Data1 : Data0;
  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_grant_id <= 1'b0;
      r_flag_tx  <= 1'b0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_flag_tx <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + BAUD_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_ack0     <= ~w_winner;
            r_ack1     <= w_winner;
            r_shift    <= w_win_data;
            r_parity   <= (^w_win_data) ^ (PARITY_ODD != 0);
            r_grant_id <= w_winner;
            r_rr_ptr   <= ~w_winner;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state   <= S_STOP;
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == STOP_LAST) begin
              // One idle cycle follows so Flag_Tx never coincides with the next Ack.
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_flag_tx <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            r_tx <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Ack0     = r_ack0;
  assign Ack1     = r_ack1;
  assign Tx       = r_tx;
  assign Busy     = r_busy;
  assign Grant_Id = r_grant_id;
  assign Flag_Tx  = r_flag_tx;

endmodule
